// File: rtl/imem_load_arbiter.sv
// -----------------------------------------------------------------------------
// imem_load_arbiter
//
// Purpose:
//   Controller in front of a 32-word instruction RAM that has a byte write port
//   and a word read port. It first sequences a host byte-stream program load
//   into the RAM. It then hands the RAM over to CPU instruction fetch. Writes
//   and reads never collide: the RAM only reads while ram_we_o is 0. The CPU is
//   stalled for the whole load.
//
// Ports:
//   clk_i          rising-edge clock
//   rst_i          synchronous active-high reset
//   load_start_i   1-cycle pulse that starts a (re)load (ignored while loading)
//   load_valid_i   host byte valid
//   load_byte_i    host byte
//   load_ready_o   block accepts a byte this cycle (combinational, LOAD only)
//   load_done_o    1-cycle pulse once the last byte's write has retired
//   cpu_stall_o    1 = CPU must not fetch
//   fetch_req_i    CPU fetch request
//   fetch_addr_i   CPU word address
//   fetch_valid_o  RAM data_out holds the requested word this cycle
//   fetch_err_o    1-cycle pulse: the request was out of range
//   ram_pc_add_o   RAM read address (fetch_addr_i in RUN, 0 otherwise)
//   ram_mem_in_o   RAM write address
//   ram_data_in_o  RAM write data
//   ram_we_o       RAM write enable
//   load_csum_o    8-bit wrapping sum of the bytes of the current load
//
// Configuration:
//   LOAD_CSUM_EN   when defined, builds the load checksum accumulator;
//                  when undefined, load_csum_o is tied to 8'h00.
// -----------------------------------------------------------------------------
module imem_load_arbiter #(
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 7,
  parameter int LOAD_LEN = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_start_i,
  input  logic              load_valid_i,
  input  logic [7:0]        load_byte_i,
  output logic              load_ready_o,
  output logic              load_done_o,
  output logic              cpu_stall_o,
  input  logic              fetch_req_i,
  input  logic [31:0]       fetch_addr_i,
  output logic              fetch_valid_o,
  output logic              fetch_err_o,
  output logic [31:0]       ram_pc_add_o,
  output logic [ADDR_W-1:0] ram_mem_in_o,
  output logic [7:0]        ram_data_in_o,
  output logic              ram_we_o,
  output logic [7:0]        load_csum_o
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN,
    RUN
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(LOAD_LEN - 1);
  localparam logic [31:0]       DEPTH_W  = 32'(DEPTH);

  state_e              state_q;
  logic [ADDR_W-1:0]   cnt_q;
  logic                ram_we_q;
  logic [ADDR_W-1:0]   ram_mem_in_q;
  logic [7:0]          ram_data_in_q;
  logic                load_done_q;
  logic                fetch_valid_q;
  logic                fetch_err_q;

  logic accept;
  logic fetch_in_range;
  logic load_begin;

  assign load_ready_o   = (state_q == LOAD);
  assign cpu_stall_o    = (state_q != RUN);
  assign accept         = load_valid_i & load_ready_o;
  assign fetch_in_range = (fetch_addr_i < DEPTH_W);
  // A start pulse only takes effect from IDLE or RUN; during LOAD/DRAIN it is dropped.
  assign load_begin     = load_start_i & ((state_q == IDLE) || (state_q == RUN));

  // The read address is muxed so the RAM only sees CPU addresses once it is handed over.
  assign ram_pc_add_o   = (state_q == RUN) ? fetch_addr_i : 32'd0;

  assign ram_we_o       = ram_we_q;
  assign ram_mem_in_o   = ram_mem_in_q;
  assign ram_data_in_o  = ram_data_in_q;
  assign load_done_o    = load_done_q;
  assign fetch_valid_o  = fetch_valid_q;
  assign fetch_err_o    = fetch_err_q;

  // Controller FSM. All pulse outputs default low each cycle; the write port
  // is registered, so a byte accepted in LOAD is written during the following
  // cycle. DRAIN is the cycle carrying the final write, after which load_done
  // is raised together with entry into RUN.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      ram_we_q      <= 1'b0;
      ram_mem_in_q  <= '0;
      ram_data_in_q <= 8'd0;
      load_done_q   <= 1'b0;
      fetch_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
    end else begin
      ram_we_q      <= 1'b0;
      load_done_q   <= 1'b0;
      fetch_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (load_start_i) begin
            state_q <= LOAD;
            cnt_q   <= '0;
          end
        end
        LOAD: begin
          if (accept) begin
            ram_we_q      <= 1'b1;
            ram_mem_in_q  <= cnt_q;
            ram_data_in_q <= load_byte_i;
            cnt_q         <= cnt_q + 1'b1;
            if (cnt_q == LAST_IDX) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          load_done_q <= 1'b1;
          state_q     <= RUN;
        end
        RUN: begin
          // A reload request wins over a fetch issued in the same cycle.
          if (load_start_i) begin
            state_q <= LOAD;
            cnt_q   <= '0;
          end else if (fetch_req_i) begin
            fetch_valid_q <= fetch_in_range;
            fetch_err_q   <= ~fetch_in_range;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

`ifdef LOAD_CSUM_EN
  logic [7:0] csum_q;
  logic [7:0] csum_d;

  // Sum restarts with each load and then simply holds, since no bytes are
  // accepted outside LOAD.
  always_comb begin
    csum_d = csum_q;
    if (load_begin) begin
      csum_d = 8'd0;
    end else if (accept) begin
      csum_d = csum_q + load_byte_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      csum_q <= 8'd0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign load_csum_o = csum_q;
`else
  logic unused_load_begin;
  assign unused_load_begin = load_begin;
  assign load_csum_o       = 8'h00;
`endif

endmodule

// File: tb/tb_imem_load_arbiter.sv
// -----------------------------------------------------------------------------
// tb_imem_load_arbiter
//
// Purpose:
//   Self-checking bench for imem_load_arbiter. A behavioural RAM is attached to
//   the DUT's RAM port. A reference model tracks the load/run phases, expected
//   writes, fetch responses and checksum. A compare process checks every DUT
//   output every cycle, and directed sequences pin known literal values.
//   Honours LOAD_CSUM_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_imem_load_arbiter;

  localparam int DEPTH    = 32;
  localparam int ADDR_W   = 7;
  localparam int LOAD_LEN = 32;

  localparam int M_IDLE  = 0;
  localparam int M_LOAD  = 1;
  localparam int M_DRAIN = 2;
  localparam int M_RUN   = 3;

  logic clk = 1'b0;
  logic rst;
  logic loadStart;
  logic loadValid;
  logic [7:0] loadByte;
  logic loadReady;
  logic loadDone;
  logic cpuStall;
  logic fetchReq;
  logic [31:0] fetchAddr;
  logic fetchValid;
  logic fetchErr;
  logic [31:0] ramPcAdd;
  logic [ADDR_W-1:0] ramMemIn;
  logic [7:0] ramDataIn;
  logic ramWe;
  logic [7:0] loadCsum;

  int checks = 0;
  int errors = 0;
  int weCount = 0;
  int doneCount = 0;

  // Clock generation.
  always #5 clk = ~clk;

  imem_load_arbiter #(
    .DEPTH(DEPTH),
    .ADDR_W(ADDR_W),
    .LOAD_LEN(LOAD_LEN)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .load_start_i(loadStart),
    .load_valid_i(loadValid),
    .load_byte_i(loadByte),
    .load_ready_o(loadReady),
    .load_done_o(loadDone),
    .cpu_stall_o(cpuStall),
    .fetch_req_i(fetchReq),
    .fetch_addr_i(fetchAddr),
    .fetch_valid_o(fetchValid),
    .fetch_err_o(fetchErr),
    .ram_pc_add_o(ramPcAdd),
    .ram_mem_in_o(ramMemIn),
    .ram_data_in_o(ramDataIn),
    .ram_we_o(ramWe),
    .load_csum_o(loadCsum)
  );

  // Behavioural instruction RAM: byte write, registered word read when not writing.
  logic [7:0] ram [DEPTH];
  logic [31:0] ramOut;
  always @(posedge clk) begin
    if (ramWe) ram[ramMemIn[4:0]] <= ramDataIn;
    else ramOut <= {24'd0, ram[ramPcAdd[4:0]]};
  end

  // Reference model: the loaded program image and the expected registered
  // responses, recomputed from the inputs seen at each rising edge.
  int mMode = M_IDLE;
  int mCount = 0;
  logic [7:0] mMem [DEPTH];
  int mFetchAddr = 0;
  logic eWe = 1'b0;
  int eAddr = 0;
  logic [7:0] eData = 8'd0;
  logic eDone = 1'b0;
  logic eValid = 1'b0;
  logic eErr = 1'b0;
  logic [7:0] eCsum = 8'd0;

  always @(posedge clk) begin
    if (rst) begin
      mMode = M_IDLE;
      mCount = 0;
      eWe = 1'b0; eDone = 1'b0; eValid = 1'b0; eErr = 1'b0;
      eCsum = 8'd0;
    end else begin
      eWe = 1'b0; eDone = 1'b0; eValid = 1'b0; eErr = 1'b0;
      if (mMode == M_IDLE) begin
        if (loadStart) begin mMode = M_LOAD; mCount = 0; eCsum = 8'd0; end
      end else if (mMode == M_LOAD) begin
        if (loadValid) begin
          eWe = 1'b1;
          eAddr = mCount;
          eData = loadByte;
          mMem[mCount] = loadByte;
          eCsum = eCsum + loadByte;
          mCount = mCount + 1;
          if (mCount == LOAD_LEN) mMode = M_DRAIN;
        end
      end else if (mMode == M_DRAIN) begin
        eDone = 1'b1;
        mMode = M_RUN;
      end else begin
        if (loadStart) begin
          mMode = M_LOAD; mCount = 0; eCsum = 8'd0;
        end else if (fetchReq) begin
          if (fetchAddr < DEPTH) begin eValid = 1'b1; mFetchAddr = int'(fetchAddr); end
          else eErr = 1'b1;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic start, input logic valid,
                               input logic [7:0] b, input logic req, input logic [31:0] addr);
    @(negedge clk);
    rst = r; loadStart = start; loadValid = valid; loadByte = b;
    fetchReq = req; fetchAddr = addr;
  endtask

  // Per-cycle comparison of every DUT output against the model.
  always @(posedge clk) begin
    #1;
    if (ramWe === 1'b1) weCount++;
    if (loadDone === 1'b1) doneCount++;
    checkOutput("load_ready", {31'd0, loadReady}, {31'd0, mMode == M_LOAD});
    checkOutput("cpu_stall", {31'd0, cpuStall}, {31'd0, mMode != M_RUN});
    checkOutput("ram_pc_add", ramPcAdd, (mMode == M_RUN) ? fetchAddr : 32'd0);
    checkOutput("ram_we", {31'd0, ramWe}, {31'd0, eWe});
    if (eWe) begin
      checkOutput("ram_mem_in", {25'd0, ramMemIn}, 32'(eAddr));
      checkOutput("ram_data_in", {24'd0, ramDataIn}, {24'd0, eData});
    end
    checkOutput("load_done", {31'd0, loadDone}, {31'd0, eDone});
    checkOutput("fetch_valid", {31'd0, fetchValid}, {31'd0, eValid});
    checkOutput("fetch_err", {31'd0, fetchErr}, {31'd0, eErr});
    if (eValid) checkOutput("fetch_data", ramOut, {24'd0, mMem[mFetchAddr]});
`ifdef LOAD_CSUM_EN
    checkOutput("load_csum", {24'd0, loadCsum}, {24'd0, eCsum});
`else
    checkOutput("load_csum", {24'd0, loadCsum}, 32'd0);
`endif
  end

  // Idles until load_done is seen, bounded to a few cycles.
  task automatic waitDone();
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 32'd0);
      @(posedge clk); #2;
      if (loadDone === 1'b1) seen = 1'b1;
    end
    checkOutput("load_done_seen", {31'd0, seen}, 32'd1);
  endtask

  logic [7:0] newBytes [LOAD_LEN];

  initial begin
    rst = 1'b1; loadStart = 1'b0; loadValid = 1'b0; loadByte = 8'd0;
    fetchReq = 1'b0; fetchAddr = 32'd0;

    // Reset held for two cycles.
    repeat (2) @(posedge clk);
    #2;
    checkOutput("rst_stall", {31'd0, cpuStall}, 32'd1);
    checkOutput("rst_ready", {31'd0, loadReady}, 32'd0);
    checkOutput("rst_we", {31'd0, ramWe}, 32'd0);
    checkOutput("rst_valid", {31'd0, fetchValid}, 32'd0);
    checkOutput("rst_done", {31'd0, loadDone}, 32'd0);

    // Load bytes 0x00..0x1F with random valid gaps.
    weCount = 0; doneCount = 0;
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 32'd0);
    for (int i = 0; i < LOAD_LEN; i++) begin
      repeat ($urandom_range(0, 2)) applyStimulus(1'b0, 1'b0, 1'b0, 8'hAA, 1'b1, 32'd3);
      applyStimulus(1'b0, 1'b0, 1'b1, 8'(i), 1'b0, 32'd0);
    end
    waitDone();
    checkOutput("done_stall", {31'd0, cpuStall}, 32'd0);
    checkOutput("we_pulses", 32'(weCount), 32'd32);
`ifdef LOAD_CSUM_EN
    checkOutput("csum_lit", {24'd0, loadCsum}, 32'h000000F0);
`else
    checkOutput("csum_lit", {24'd0, loadCsum}, 32'h00000000);
`endif

    // Fetches: word 5, then 0,1,2 back-to-back.
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 32'd5);
    @(posedge clk); #2;
    checkOutput("fetch5_valid", {31'd0, fetchValid}, 32'd1);
    checkOutput("fetch5_data", ramOut, 32'h00000005);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 32'(i));
      @(posedge clk); #2;
      checkOutput("b2b_valid", {31'd0, fetchValid}, 32'd1);
      checkOutput("b2b_data", ramOut, 32'(i));
    end

    // Out-of-range fetch.
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 32'd40);
    @(posedge clk); #2;
    checkOutput("oor_err", {31'd0, fetchErr}, 32'd1);
    checkOutput("oor_valid", {31'd0, fetchValid}, 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 32'd0);
    @(posedge clk); #2;
    checkOutput("oor_err_pulse", {31'd0, fetchErr}, 32'd0);
    checkOutput("done_once", 32'(doneCount), 32'd1);

    // Reload request together with a fetch: the fetch is dropped.
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 1'b1, 32'd3);
    @(posedge clk); #2;
    checkOutput("race_valid", {31'd0, fetchValid}, 32'd0);
    checkOutput("race_err", {31'd0, fetchErr}, 32'd0);
    checkOutput("race_ready", {31'd0, loadReady}, 32'd1);

    // Reset after 10 bytes, then a full reload of new bytes.
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b1, 8'($urandom), 1'b0, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 1'b0, 32'd0);
    @(posedge clk); #2;
    checkOutput("midrst_we", {31'd0, ramWe}, 32'd0);
    checkOutput("midrst_ready", {31'd0, loadReady}, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 1'b0, 32'd0);
    for (int i = 0; i < LOAD_LEN; i++) begin
      newBytes[i] = 8'($urandom);
      applyStimulus(1'b0, 1'b0, 1'b1, newBytes[i], 1'b0, 32'd0);
    end
    waitDone();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 32'd9);
    @(posedge clk); #2;
    checkOutput("reload_w9", ramOut, {24'd0, newBytes[9]});

    // Random traffic: fetches, reloads, byte gaps and rare resets.
    for (int c = 0; c < 1500; c++) begin
      applyStimulus(($urandom_range(0, 199) == 0), ($urandom_range(0, 24) == 0),
                    ($urandom_range(0, 1) == 1), 8'($urandom),
                    ($urandom_range(0, 9) < 7), 32'($urandom_range(0, 40)));
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 32'd0);
    repeat (3) @(posedge clk);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
